// File: rtl/uart_tx_frame_pkg.sv
// Shared definitions for the parametrised UART transmitter: state encoding,
// parity mode constants and a constant-evaluable ceiling-log2 helper.
package uart_tx_frame_pkg;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b00_0001,
        ST_START  = 6'b00_0010,
        ST_DATA   = 6'b00_0100,
        ST_PARITY = 6'b00_1000,
        ST_STOP   = 6'b01_0000,
        ST_FINAL  = 6'b10_0000
    } tx_state_e;

    localparam int PARITY_NONE = 32'sd0;
    localparam int PARITY_ODD  = 32'sd1;
    localparam int PARITY_EVEN = 32'sd2;

    // Smallest width w with 2**w >= value; used to size counters.
    function automatic int clog2(input int value);
        int width;
        width = 32'sd0;
        while ((32'sd1 <<< width) < value) begin
            width = width + 32'sd1;
        end
        return width;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..BIT_CLOCKS-1 and flags the last cycle of each
// bit period. A clear restarts the period so a frame starts on a full bit.
module uart_baud_tick
    import uart_tx_frame_pkg::*;
#(
    parameter int BIT_CLOCKS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int               CNT_W    = clog2(BIT_CLOCKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLOCKS - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_r;

    // Bit-period counter, wrapping at the last cycle of each bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (clear) begin
            cnt_r <= CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign bit_end = (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with valid/ready input handshake, 5..9 data
// bits, optional odd/even parity and 1 or 2 stop bits. Line outputs are registered.
module uart_tx_frame
    import uart_tx_frame_pkg::*;
#(
    parameter int CLK_FREQ_KHz  = 50000,
    parameter int BAUD_RATE_BPS = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_MODE   = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_valid,
    input  logic [DATA_BITS-1:0] data,
    output logic                 data_ready,
    output logic                 tx,
    output logic                 tx_en,
    output logic                 tx_done
);

    localparam int BIT_CLOCKS = (CLK_FREQ_KHz * 32'sd1000) / BAUD_RATE_BPS;
    localparam bit PARITY_EN  = (PARITY_MODE != PARITY_NONE);

    localparam int                DCNT_W    = clog2(DATA_BITS);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DATA_BITS - 32'sd1);
    localparam logic [DCNT_W-1:0] DCNT_ZERO = {DCNT_W{1'b0}};
    localparam logic [0:0]        SCNT_LAST = 1'(STOP_BITS - 32'sd1);

    generate
        if (DATA_BITS < 32'sd5 || DATA_BITS > 32'sd9) begin : g_bad_data_bits
            $error("uart_tx_frame: DATA_BITS must be in 5..9");
        end
        if (PARITY_MODE < 32'sd0 || PARITY_MODE > 32'sd2) begin : g_bad_parity
            $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
        end
        if (STOP_BITS < 32'sd1 || STOP_BITS > 32'sd2) begin : g_bad_stop_bits
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
        if (BIT_CLOCKS < 32'sd2) begin : g_bad_bit_clocks
            $error("uart_tx_frame: clock/baud ratio must be at least 2");
        end
    endgenerate

    // Parity bit that makes the total count of ones odd or even.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
        logic ones_odd;
        ones_odd = ^word;
        if (PARITY_MODE == PARITY_ODD) begin
            return ~ones_odd;
        end else begin
            return ones_odd;
        end
    endfunction

    tx_state_e              state_r,  state_next_s;
    logic [DATA_BITS-1:0]   shift_r,  shift_next_s;
    logic                   parity_r, parity_next_s;
    logic [DCNT_W-1:0]      dcnt_r,   dcnt_next_s;
    logic [0:0]             scnt_r,   scnt_next_s;
    logic                   tx_r,      tx_next_s;
    logic                   tx_en_r,   tx_en_next_s;
    logic                   tx_done_r, tx_done_next_s;
    logic                   accept_s;
    logic                   clear_s;
    logic                   bit_end_s;

    uart_baud_tick #(
        .BIT_CLOCKS (BIT_CLOCKS)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_s),
        .bit_end (bit_end_s)
    );

    assign data_ready = (state_r == ST_IDLE);
    assign accept_s   = data_valid & data_ready;

    // Next-state logic: frame sequencing and datapath updates.
    always_comb begin
        state_next_s  = state_r;
        shift_next_s  = shift_r;
        parity_next_s = parity_r;
        dcnt_next_s   = dcnt_r;
        scnt_next_s   = scnt_r;
        clear_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s  = ST_START;
                    shift_next_s  = data;
                    parity_next_s = parity_of(data);
                    dcnt_next_s   = DCNT_ZERO;
                    scnt_next_s   = 1'b0;
                    clear_s       = 1'b1;
                end else begin
                    state_next_s  = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_next_s = {1'b0, shift_r[DATA_BITS-1:1]};
                    if (dcnt_r == DCNT_LAST) begin
                        dcnt_next_s = DCNT_ZERO;
                        if (PARITY_EN) begin
                            state_next_s = ST_PARITY;
                        end else begin
                            state_next_s = ST_STOP;
                        end
                    end else begin
                        dcnt_next_s = dcnt_r + 1'b1;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    if (scnt_r == SCNT_LAST) begin
                        scnt_next_s  = 1'b0;
                        state_next_s = ST_FINAL;
                    end else begin
                        scnt_next_s  = scnt_r + 1'b1;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_FINAL: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Line outputs decoded from the upcoming state so they can be registered.
    always_comb begin
        tx_next_s      = 1'b1;
        tx_en_next_s   = 1'b0;
        tx_done_next_s = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                tx_next_s = 1'b1;
            end
            ST_START: begin
                tx_next_s    = 1'b0;
                tx_en_next_s = 1'b1;
            end
            ST_DATA: begin
                tx_next_s    = shift_next_s[0];
                tx_en_next_s = 1'b1;
            end
            ST_PARITY: begin
                tx_next_s    = parity_next_s;
                tx_en_next_s = 1'b1;
            end
            ST_STOP: begin
                tx_next_s    = 1'b1;
                tx_en_next_s = 1'b1;
            end
            ST_FINAL: begin
                tx_next_s      = 1'b1;
                tx_done_next_s = 1'b1;
            end
            default: begin
                tx_next_s = 1'b1;
            end
        endcase
    end

    // State, datapath and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            shift_r   <= {DATA_BITS{1'b0}};
            parity_r  <= 1'b0;
            dcnt_r    <= DCNT_ZERO;
            scnt_r    <= 1'b0;
            tx_r      <= 1'b1;
            tx_en_r   <= 1'b0;
            tx_done_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            shift_r   <= shift_next_s;
            parity_r  <= parity_next_s;
            dcnt_r    <= dcnt_next_s;
            scnt_r    <= scnt_next_s;
            tx_r      <= tx_next_s;
            tx_en_r   <= tx_en_next_s;
            tx_done_r <= tx_done_next_s;
        end
    end

    assign tx      = tx_r;
    assign tx_en   = tx_en_r;
    assign tx_done = tx_done_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four instances (8N1, 8E1, 8O1, 5N2) at
// ten clocks per bit, checked cycle by cycle against hand-derived bit sequences.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dv;
    logic [7:0] din;
    logic [3:0] rdy;
    logic [3:0] txl;
    logic [3:0] en;
    logic [3:0] done;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLK_FREQ_KHz(1000), .BAUD_RATE_BPS(100000), .DATA_BITS(8),
                    .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .data_valid(dv[0]), .data(din),
        .data_ready(rdy[0]), .tx(txl[0]), .tx_en(en[0]), .tx_done(done[0]));

    uart_tx_frame #(.CLK_FREQ_KHz(1000), .BAUD_RATE_BPS(100000), .DATA_BITS(8),
                    .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .data_valid(dv[1]), .data(din),
        .data_ready(rdy[1]), .tx(txl[1]), .tx_en(en[1]), .tx_done(done[1]));

    uart_tx_frame #(.CLK_FREQ_KHz(1000), .BAUD_RATE_BPS(100000), .DATA_BITS(8),
                    .PARITY_MODE(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .data_valid(dv[2]), .data(din),
        .data_ready(rdy[2]), .tx(txl[2]), .tx_en(en[2]), .tx_done(done[2]));

    uart_tx_frame #(.CLK_FREQ_KHz(1000), .BAUD_RATE_BPS(100000), .DATA_BITS(5),
                    .PARITY_MODE(0), .STOP_BITS(2)) u_5n2 (
        .clk(clk), .rst(rst), .data_valid(dv[3]), .data(din[4:0]),
        .data_ready(rdy[3]), .tx(txl[3]), .tx_en(en[3]), .tx_done(done[3]));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int idx, input string tag);
        check($sformatf("%s tx[%0d]", tag, idx), {7'd0, txl[idx]}, 8'd1);
        check($sformatf("%s en[%0d]", tag, idx), {7'd0, en[idx]}, 8'd0);
        check($sformatf("%s done[%0d]", tag, idx), {7'd0, done[idx]}, 8'd0);
        check($sformatf("%s rdy[%0d]", tag, idx), {7'd0, rdy[idx]}, 8'd1);
    endtask

    // Caller leaves the DUT in IDLE with dv/din set; the first tick is the accept edge.
    task automatic run_frame(input int idx, input logic [7:0] dat, input int nbits,
                             input bit par_en, input logic par, input int nstop,
                             input bit hold, input int glitch_at);
        int   nb;
        int   cyc;
        logic exp_tx;
        nb  = 1 + nbits + (par_en ? 1 : 0) + nstop;
        cyc = 0;
        for (int b = 0; b < nb; b++) begin
            if (b == 0) exp_tx = 1'b0;
            else if (b <= nbits) exp_tx = dat[b-1];
            else if (par_en && b == nbits + 1) exp_tx = par;
            else exp_tx = 1'b1;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (cyc == 0 && !hold) dv[idx] = 1'b0;
                if (glitch_at >= 0 && cyc == glitch_at) begin
                    dv[idx] = 1'b1;
                    din     = 8'hFF;
                end else if (glitch_at >= 0 && cyc == glitch_at + 1) begin
                    dv[idx] = 1'b0;
                end
                check($sformatf("frame%0d tx c%0d", idx, cyc), {7'd0, txl[idx]}, {7'd0, exp_tx});
                check($sformatf("frame%0d en c%0d", idx, cyc), {7'd0, en[idx]}, 8'd1);
                check($sformatf("frame%0d rdy c%0d", idx, cyc), {7'd0, rdy[idx]}, 8'd0);
                check($sformatf("frame%0d done c%0d", idx, cyc), {7'd0, done[idx]}, 8'd0);
                cyc++;
            end
        end
        tick();
        check($sformatf("final%0d tx", idx), {7'd0, txl[idx]}, 8'd1);
        check($sformatf("final%0d en", idx), {7'd0, en[idx]}, 8'd0);
        check($sformatf("final%0d done", idx), {7'd0, done[idx]}, 8'd1);
        check($sformatf("final%0d rdy", idx), {7'd0, rdy[idx]}, 8'd0);
    endtask

    initial begin
        rst = 1'b1;
        dv  = 4'b0000;
        din = 8'h00;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) check_idle(i, "reset");
        rst = 1'b0;
        tick();
        check_idle(0, "post_reset");

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        din = 8'hA5; dv[0] = 1'b1;
        run_frame(0, 8'hA5, 8, 1'b0, 1'b0, 1, 1'b0, -1);
        tick();
        check_idle(0, "after_8n1");

        // 0xA5 has four ones: even parity 0, odd parity 1
        din = 8'hA5; dv[1] = 1'b1;
        run_frame(1, 8'hA5, 8, 1'b1, 1'b0, 1, 1'b0, -1);
        tick();
        check_idle(1, "after_8e1");
        din = 8'hA5; dv[2] = 1'b1;
        run_frame(2, 8'hA5, 8, 1'b1, 1'b1, 1, 1'b0, -1);
        tick();
        check_idle(2, "after_8o1");

        // 5 data bits, 2 stop bits, 0x13: 1,1,0,0,1
        din = 8'h13; dv[3] = 1'b1;
        run_frame(3, 8'h13, 5, 1'b0, 1'b0, 2, 1'b0, -1);
        tick();
        check_idle(3, "after_5n2");

        // Back-to-back with data_valid held: FINAL + one IDLE cycle between frames
        din = 8'h3C; dv[0] = 1'b1;
        run_frame(0, 8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, -1);
        din = 8'h81;
        tick();
        check_idle(0, "gap1");
        run_frame(0, 8'h81, 8, 1'b0, 1'b0, 1, 1'b1, -1);
        din = 8'h5A;
        tick();
        check_idle(0, "gap2");
        run_frame(0, 8'h5A, 8, 1'b0, 1'b0, 1, 1'b0, -1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_idle(0, "after_burst");
        end

        // data_valid pulse while busy is ignored; 0xA5 frame is unchanged
        din = 8'hA5; dv[1] = 1'b1;
        run_frame(1, 8'hA5, 8, 1'b1, 1'b0, 1, 1'b0, 35);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_idle(1, "after_glitch");
        end

        // Reset in the middle of data bit 4 of a 0x00 frame
        din = 8'h00; dv[0] = 1'b1;
        tick();
        dv[0] = 1'b0;
        repeat (54) tick();
        check("mid_bit4 tx", {7'd0, txl[0]}, 8'd0);
        check("mid_bit4 en", {7'd0, en[0]}, 8'd1);
        rst = 1'b1;
        tick();
        check_idle(0, "abort");
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_idle(0, "after_abort");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
